bpc_frame_packer: RTL



---
 rtl/bpc_frame_packer_if.sv | 26 ++
 rtl/bpc_frame_packer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bpc_frame_packer_if.sv
// Beat-stream bundle around bpc_frame_packer; signal names follow the packer's
// view (*_i flows into the packer, *_o flows out of it).
interface bpc_frame_packer_if #(
   parameter int DATA_W = 64
);
   logic [DATA_W-1:0] data_i;
   logic              valid_i;
   logic              ready_o;
   logic              sop_i;
   logic              eop_i;
   logic [DATA_W-1:0] data_o;
   logic              valid_o;
   logic              ready_i;
   logic              sop_o;
   logic              eop_o;

   modport master (
      output data_i, valid_i, sop_i, eop_i, ready_i,
      input  ready_o, data_o, valid_o, sop_o, eop_o
   );

   modport slave (
      input  data_i, valid_i, sop_i, eop_i, ready_i,
      output ready_o, data_o, valid_o, sop_o, eop_o
   );
endinterface

// File: rtl/bpc_frame_packer.sv
// Store-and-forward framer: buffers one sop..eop block, then emits a length header and the payload.
// Optional header checksum is enabled by defining BPC_PACK_CSUM_EN.
module bpc_frame_packer #(
   parameter int          DATA_W = 64,
   parameter int          DEPTH  = 32,
   parameter logic [15:0] MAGIC  = 16'hB9C0
) (
   input logic               clk,
   input logic               rst,
   bpc_frame_packer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, FILL, HDR, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [7:0]        seq_q, seq_d;
   logic              ovf_q, ovf_d;
   logic              ready_q, ready_d;
   logic              valid_q, valid_d;
   logic              sop_q, sop_d;
   logic              eop_q, eop_d;
   logic [DATA_W-1:0] data_q, data_d;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              in_fire, accept, wr_en, out_fire;
   logic [AW-1:0]     wr_addr;
   logic [15:0]       csum_hdr;

   // ready_q is only high in IDLE/FILL, so in_fire already implies one of those states.
   always_comb begin
      in_fire = bus.valid_i & ready_q;
      accept  = in_fire & (bus.sop_i | (state_q == FILL));
      wr_en   = accept & (bus.sop_i | (count_q != FULL));
      wr_addr = bus.sop_i ? '0 : count_q[AW-1:0];
   end

   // NOTE: the payload RAM has no reset; every word is rewritten before it is read back.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= bus.data_i;
   end

`ifdef BPC_PACK_CSUM_EN
   logic [15:0] csum_q, csum_d, fold;

   always_comb begin
      fold   = bus.data_i[63:48] ^ bus.data_i[47:32] ^ bus.data_i[31:16] ^ bus.data_i[15:0];
      csum_d = csum_q;
      if (wr_en) csum_d = (bus.sop_i ? 16'h0000 : csum_q) ^ fold;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) csum_q <= 16'h0000;
      else     csum_q <= csum_d;
   end

   assign csum_hdr = csum_d;
`else
   assign csum_hdr = 16'h0000;
`endif

   // NOTE: every *_d gets its hold value first so no path through this block can infer a latch.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      seq_d    = seq_q;
      ovf_d    = ovf_q;
      ready_d  = ready_q;
      valid_d  = valid_q;
      sop_d    = sop_q;
      eop_d    = eop_q;
      data_d   = data_q;
      out_fire = valid_q & bus.ready_i;

      unique case (state_q)
         IDLE, FILL: begin
            ready_d = 1'b1;
            if (accept) begin
               if (bus.sop_i) begin
                  count_d = CW'(1);
                  ovf_d   = 1'b0;
               end else if (count_q == FULL) begin
                  ovf_d = 1'b1;
               end else begin
                  count_d = count_q + CW'(1);
               end
               state_d = FILL;
               // Header is built from the post-update count/ovf/checksum so it is valid next cycle.
               if (bus.eop_i) begin
                  state_d = HDR;
                  ready_d = 1'b0;
                  valid_d = 1'b1;
                  sop_d   = 1'b1;
                  eop_d   = 1'b0;
                  data_d  = {MAGIC, seq_q, 7'd0, ovf_d, 16'(count_d), csum_hdr};
               end
            end
         end
         HDR: begin
            if (out_fire) begin
               state_d  = DRAIN;
               sop_d    = 1'b0;
               data_d   = mem[0];
               eop_d    = (count_q == CW'(1));
               rd_ptr_d = CW'(1);
            end
         end
         DRAIN: begin
            if (out_fire) begin
               if (eop_q) begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  eop_d   = 1'b0;
                  ready_d = 1'b1;
                  seq_d   = seq_q + 8'd1;
               end else begin
                  data_d   = mem[rd_ptr_q[AW-1:0]];
                  eop_d    = (rd_ptr_q == count_q - CW'(1));
                  rd_ptr_d = rd_ptr_q + CW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   // NOTE: combinational next-state uses blocking '=', this register stage uses '<=' only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         count_q  <= '0;
         rd_ptr_q <= '0;
         seq_q    <= 8'd0;
         ovf_q    <= 1'b0;
         ready_q  <= 1'b0;
         valid_q  <= 1'b0;
         sop_q    <= 1'b0;
         eop_q    <= 1'b0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         seq_q    <= seq_d;
         ovf_q    <= ovf_d;
         ready_q  <= ready_d;
         valid_q  <= valid_d;
         sop_q    <= sop_d;
         eop_q    <= eop_d;
         data_q   <= data_d;
      end
   end

   assign bus.ready_o = ready_q;
   assign bus.valid_o = valid_q;
   assign bus.sop_o   = sop_q;
   assign bus.eop_o   = eop_q;
   assign bus.data_o  = data_q;
endmodule
